// File: rtl/button_debounce_multi.sv
// button_debounce_multi: N-channel pushbutton debouncer.
// Each channel has its own synchroniser, a four-state debounce FSM with a
// stability counter, a registered clean level, and one-cycle press/release pulses.
// Optional feature macro: LONG_PRESS_EN adds a per-channel hold counter that
// raises a one-cycle long_press pulse once a press has lasted LONG_CYCLES cycles.
// Without the macro, long_press is tied to 0.
module button_debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 0,
    parameter int LONG_CYCLES     = 10000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            state_t                 state_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   out_reg;
            logic                   press_reg;
            logic                   release_reg;
            logic                   rise_event;
            logic                   fall_event;

            // Shift the raw pin through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_in[gi]};
                end
            end

            // Pin polarity is normalised here so the FSM always sees 1 = pressed.
            assign s = (ACTIVE_LOW != 0) ? ~sync_reg[SYNC_STAGES-1] : sync_reg[SYNC_STAGES-1];

            // The edge on which a pending level change is finally accepted.
            assign rise_event = (state_reg == WAIT_HI) && s && (cnt_reg == CNT_LAST);
            assign fall_event = (state_reg == WAIT_LO) && !s && (cnt_reg == CNT_LAST);

            // Debounce FSM with registered level and pulse outputs.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg   <= STABLE_LO;
                    cnt_reg     <= '0;
                    out_reg     <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    case (state_reg)
                        STABLE_LO: begin
                            cnt_reg <= '0;
                            if (s) begin
                                state_reg <= WAIT_HI;
                            end
                        end
                        WAIT_HI: begin
                            if (!s) begin
                                // Bounce back to the old level: abandon quietly.
                                state_reg <= STABLE_LO;
                                cnt_reg   <= '0;
                            end else if (rise_event) begin
                                state_reg <= STABLE_HI;
                                cnt_reg   <= '0;
                                out_reg   <= 1'b1;
                                press_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        STABLE_HI: begin
                            cnt_reg <= '0;
                            if (!s) begin
                                state_reg <= WAIT_LO;
                            end
                        end
                        WAIT_LO: begin
                            if (s) begin
                                state_reg <= STABLE_HI;
                                cnt_reg   <= '0;
                            end else if (fall_event) begin
                                state_reg   <= STABLE_LO;
                                cnt_reg     <= '0;
                                out_reg     <= 1'b0;
                                release_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= STABLE_LO;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign button_out[gi]    = out_reg;
            assign press_pulse[gi]   = press_reg;
            assign release_pulse[gi] = release_reg;

`ifdef LONG_PRESS_EN
            localparam int LONG_W = $clog2(LONG_CYCLES + 1);
            localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
            localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

            logic [LONG_W-1:0] hold_reg;
            logic              long_reg;

            // Count how long the accepted press has lasted; pulse once at the threshold.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else begin
                    long_reg <= 1'b0;
                    if (rise_event || fall_event) begin
                        hold_reg <= '0;
                    end else if ((state_reg == STABLE_HI || state_reg == WAIT_LO)
                                 && hold_reg != LONG_MAX) begin
                        hold_reg <= hold_reg + 1'b1;
                        if (hold_reg == LONG_LAST) begin
                            long_reg <= 1'b1;
                        end
                    end
                end
            end

            assign long_press[gi] = long_reg;
`else
            assign long_press[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_multi.sv
// Testbench for button_debounce_multi: directed scenarios followed by random
// per-channel hold/bounce patterns, all checked every cycle against a
// run-length reference model (a level is accepted once the synchronised input
// has differed from the accepted level for DEBOUNCE_CYCLES+1 consecutive samples).
module tb_button_debounce_multi;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int SS = 2;
    localparam int AL = 0;
    localparam int LC = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] button_in;
    logic [CH-1:0] button_out;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] long_press;

    int n_cmp = 0;
    int n_err = 0;

    button_debounce_multi #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .ACTIVE_LOW      (AL),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_in     (button_in),
        .button_out    (button_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] m_hist [SS];
    logic [CH-1:0] m_out     = '0;
    logic [CH-1:0] m_press   = '0;
    logic [CH-1:0] m_release = '0;
    logic [CH-1:0] m_long    = '0;
    int            m_run  [CH];
    int            m_hold [CH];

    always @(posedge clk) begin
        m_press   = '0;
        m_release = '0;
        m_long    = '0;
        if (reset) begin
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            m_out = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                logic sv;
                sv = m_hist[SS-1][c] ^ (AL != 0);
                if (sv != m_out[c]) m_run[c] = m_run[c] + 1;
                else                m_run[c] = 0;
                if (m_run[c] == DB + 1) begin
                    m_run[c]  = 0;
                    m_out[c]  = ~m_out[c];
                    m_hold[c] = 0;
                    if (m_out[c]) m_press[c]   = 1'b1;
                    else          m_release[c] = 1'b1;
                end else if (m_out[c] && m_hold[c] < LC) begin
                    m_hold[c] = m_hold[c] + 1;
                    if (m_hold[c] == LC) m_long[c] = 1'b1;
                end
            end
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = button_in;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        logic [CH-1:0] exp_long;
`ifdef LONG_PRESS_EN
        exp_long = m_long;
`else
        exp_long = '0;
`endif
        check_val("button_out", 32'(button_out), 32'(m_out));
        check_val("press_pulse", 32'(press_pulse), 32'(m_press));
        check_val("release_pulse", 32'(release_pulse), 32'(m_release));
        check_val("long_press", 32'(long_press), 32'(exp_long));
        check_val("press_and_release", 32'(press_pulse & release_pulse), 32'd0);
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int tmr [CH];

        // Reset held 3 cycles with all buttons pressed.
        reset = 1'b1;
        button_in = 4'hF;
        ticks(3);
        check_val("reset_out", 32'(button_out), 32'd0);
        reset = 1'b0;
        ticks(6);
        check_val("reset_press_early", 32'(press_pulse), 32'd0);
        ticks(1);
        check_val("reset_press_7", 32'(press_pulse), 32'hF);
        ticks(1);
        check_val("reset_press_once", 32'(press_pulse), 32'd0);
        button_in = 4'h0;
        ticks(12);

        // Clean press on ch0.
        button_in[0] = 1'b1;
        ticks(7);
        check_val("ch0_press_7", 32'(press_pulse[0]), 32'd1);
        ticks(1);
        check_val("ch0_pulse_len", 32'(press_pulse[0]), 32'd0);
        check_val("ch0_level", 32'(button_out[0]), 32'd1);

        // 3-cycle glitch on ch1 is rejected, 5-cycle one is accepted.
        button_in[1] = 1'b1;
        ticks(3);
        button_in[1] = 1'b0;
        ticks(12);
        check_val("ch1_glitch3", 32'(button_out[1]), 32'd0);
        button_in[1] = 1'b1;
        ticks(5);
        button_in[1] = 1'b0;
        ticks(2);
        check_val("ch1_glitch5", 32'(press_pulse[1]), 32'd1);
        ticks(12);

        // Bounce on ch2, press then release.
        button_in[2] = 1'b1; ticks(1);
        button_in[2] = 1'b0; ticks(1);
        button_in[2] = 1'b1; ticks(1);
        button_in[2] = 1'b0; ticks(1);
        button_in[2] = 1'b1;
        ticks(7);
        check_val("ch2_bounce_press", 32'(press_pulse[2]), 32'd1);
        ticks(5);
        button_in[2] = 1'b0; ticks(1);
        button_in[2] = 1'b1; ticks(1);
        button_in[2] = 1'b0; ticks(1);
        button_in[2] = 1'b1; ticks(1);
        button_in[2] = 1'b0;
        ticks(7);
        check_val("ch2_bounce_release", 32'(release_pulse[2]), 32'd1);
        ticks(5);

        // Simultaneous ch0 press and ch3 release.
        button_in[0] = 1'b0;
        button_in[3] = 1'b1;
        ticks(12);
        button_in[0] = 1'b1;
        button_in[3] = 1'b0;
        ticks(7);
        check_val("conc_press0", 32'(press_pulse[0]), 32'd1);
        check_val("conc_release3", 32'(release_pulse[3]), 32'd1);
        ticks(5);

        // Reset mid-debounce on ch1 with the input held through it.
        button_in[1] = 1'b1;
        ticks(5);
        reset = 1'b1;
        ticks(2);
        check_val("midrst_press", 32'(press_pulse), 32'd0);
        check_val("midrst_out", 32'(button_out), 32'd0);
        reset = 1'b0;
        ticks(7);
        check_val("midrst_repress", 32'(press_pulse[1]), 32'd1);
        ticks(20);
`ifdef LONG_PRESS_EN
        check_val("long_ch1", 32'(long_press[1]), 32'd1);
`else
        check_val("long_ch1_off", 32'(long_press[1]), 32'd0);
`endif
        ticks(15);
        button_in = 4'h0;
        ticks(12);

        // Random hold/bounce patterns per channel, with occasional resets.
        for (int c = 0; c < CH; c++) tmr[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if (tmr[c] == 0) begin
                    button_in[c] = ~button_in[c];
                    tmr[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                         : int'($urandom_range(1, 8));
                end else begin
                    tmr[c] = tmr[c] - 1;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            ticks(1);
        end
        reset = 1'b0;
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
